// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// Optional sticky flag accumulation is enabled by defining ALU_ARB_STICKY_FLAGS_EN.
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid_i,
    output logic [1:0]     req_ready_o,
    input  logic [2*N-1:0] req_a_i,
    input  logic [2*N-1:0] req_b_i,
    input  logic [7:0]     req_op_i,
    output logic [1:0]     rsp_valid_o,
    input  logic [1:0]     rsp_ready_i,
    output logic [2*N-1:0] rsp_data_o,
    output logic [7:0]     rsp_flags_o,
    output logic [1:0]     rsp_err_o,
    output logic [N-1:0]   alu_a_o,
    output logic [N-1:0]   alu_b_o,
    output logic [3:0]     alu_control_o,
    input  logic [N-1:0]   alu_result_i,
    input  logic [3:0]     alu_flags_i,
    output logic           busy_o,
    output logic [3:0]     sticky_flags_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // Opcodes above 9 have no ALU meaning and are answered with an error response.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op > 4'd9);
    endfunction

    state_t         state_r;
    logic           last_grant_r;
    logic           owner_r;
    logic           illegal_r;
    logic           busy_r;
    logic [N-1:0]   alu_a_r;
    logic [N-1:0]   alu_b_r;
    logic [3:0]     alu_ctrl_r;
    logic [1:0]     rsp_valid_r;
    logic [2*N-1:0] rsp_data_r;
    logic [7:0]     rsp_flags_r;
    logic [1:0]     rsp_err_r;

    logic [1:0]     eligible_s;
    logic           grant_valid_s;
    logic           grant_idx_s;
    logic [1:0]     req_ready_s;
    logic [N-1:0]   sel_a_s;
    logic [N-1:0]   sel_b_s;
    logic [3:0]     sel_op_s;
    logic [1:0]     owner_oh_s;

    // A full response slot blocks its requester until the slot is drained.
    assign eligible_s = req_valid_i & ~rsp_valid_r;
    assign owner_oh_s = owner_r ? 2'b10 : 2'b01;

    // Round-robin grant decision and ready generation, only while idle.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        req_ready_s   = 2'b00;
        if (state_r == IDLE) begin
            case (eligible_s)
                2'b01: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = 1'b0;
                end
                2'b10: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = 1'b1;
                end
                2'b11: begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = ~last_grant_r;
                end
                default: begin
                    grant_valid_s = 1'b0;
                    grant_idx_s   = 1'b0;
                end
            endcase
            if (grant_valid_s) begin
                req_ready_s = grant_idx_s ? 2'b10 : 2'b01;
            end else begin
                req_ready_s = 2'b00;
            end
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        if (grant_idx_s) begin
            sel_a_s  = req_a_i[2*N-1:N];
            sel_b_s  = req_b_i[2*N-1:N];
            sel_op_s = req_op_i[7:4];
        end else begin
            sel_a_s  = req_a_i[N-1:0];
            sel_b_s  = req_b_i[N-1:0];
            sel_op_s = req_op_i[3:0];
        end
    end

    // Control FSM with ALU operand registers and per-requester response slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            illegal_r    <= 1'b0;
            busy_r       <= 1'b0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_ctrl_r   <= 4'd0;
            rsp_valid_r  <= 2'b00;
            rsp_data_r   <= '0;
            rsp_flags_r  <= 8'h00;
            rsp_err_r    <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rsp_valid_r[k] && rsp_ready_i[k]) begin
                    rsp_valid_r[k]         <= 1'b0;
                    rsp_data_r[k*N +: N]   <= '0;
                    rsp_flags_r[k*4 +: 4]  <= 4'b0000;
                    rsp_err_r[k]           <= 1'b0;
                end
            end
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        state_r    <= EXEC;
                        busy_r     <= 1'b1;
                        owner_r    <= grant_idx_s;
                        alu_a_r    <= sel_a_s;
                        alu_b_r    <= sel_b_s;
                        illegal_r  <= is_illegal_op(sel_op_s);
                        // Keep the ALU on a harmless add for illegal opcodes.
                        alu_ctrl_r <= is_illegal_op(sel_op_s) ? 4'd0 : sel_op_s;
                    end else begin
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end
                end
                EXEC: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    last_grant_r <= owner_r;
                    for (int k = 0; k < 2; k++) begin
                        if (owner_oh_s[k]) begin
                            rsp_valid_r[k]        <= 1'b1;
                            rsp_data_r[k*N +: N]  <= illegal_r ? '0 : alu_result_i;
                            rsp_flags_r[k*4 +: 4] <= illegal_r ? 4'b0000 : alu_flags_i;
                            rsp_err_r[k]          <= illegal_r;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ARB_STICKY_FLAGS_EN
    logic [3:0] sticky_r;

    // OR-accumulate flags of every legal operation, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 4'b0000;
        end else if ((state_r == EXEC) && !illegal_r) begin
            sticky_r <= sticky_r | alu_flags_i;
        end else begin
            sticky_r <= sticky_r;
        end
    end

    assign sticky_flags_o = sticky_r;
`else
    assign sticky_flags_o = 4'b0000;
`endif

    assign req_ready_o   = req_ready_s;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_data_o    = rsp_data_r;
    assign rsp_flags_o   = rsp_flags_r;
    assign rsp_err_o     = rsp_err_r;
    assign alu_a_o       = alu_a_r;
    assign alu_b_o       = alu_b_r;
    assign alu_control_o = alu_ctrl_r;
    assign busy_o        = busy_r;

endmodule
